uart_tx_fifo: RTL

//   Parametrised UART transmitter with a built-in transmit FIFO for the MMIO UART.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_fifo.sv | 70 +++++++
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by the transmitter and the receiver.
// Latency: none (types, constants and functions only).
// Backpressure: not applicable.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // System clocks per line bit (truncating division).
  function automatic int clk_per_bit(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count and registered read data.
// Latency: a popped word appears on o_rdata one edge after the pop.
// Backpressure: pushes while full and pops while empty are ignored.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic [WIDTH-1:0] rdata_q;
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (level_q == LW'(DEPTH));
  assign o_empty = (level_q == '0);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_level = level_q;
  assign o_rdata = rdata_q;

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  // Pointers, occupancy and the read data register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      level_q <= level_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rdata_q  <= mem_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frames go out LSB first, back to back with no idle gap.
// Latency: push into an idle empty block on edge 0, pop on edge 1, start bit on the line from edge 2.
// Backpressure: o_ready drops while the FIFO is full; pushes while not ready are dropped.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int      CLOCK_HZ   = 50_000_000,
  parameter int      BAUD_RATE  = 115_200,
  parameter int      DATA_BITS  = 8,
  parameter parity_e PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 16,
  localparam int     LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_uart_tx,
  output logic                 o_busy,
  output logic [LVL_W-1:0]     o_level
);

  localparam int CLK_PER_BIT = clk_per_bit(CLOCK_HZ, BAUD_RATE);
  localparam int CNT_W       = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int BIT_W       = $clog2(DATA_BITS);

  if (CLK_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLOCK_HZ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
  end

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LVL_W-1:0]     fifo_level;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 push;
  logic                 pop;
  logic                 tick;
  logic                 last_data;
  logic                 last_stop;
  logic                 line_bit;

  assign o_ready   = !fifo_full;
  assign push      = i_valid && o_ready;
  assign tick      = (cnt_q == CNT_W'(CLK_PER_BIT - 1));
  assign last_data = (bit_q == BIT_W'(DATA_BITS - 1));
  assign last_stop = (bit_q == BIT_W'(STOP_BITS - 1));
  // Pop when idle, or on the final stop cycle so the next start bit follows with no gap.
  assign pop       = !fifo_empty &&
                     ((state_q == IDLE) || (state_q == STOP && tick && last_stop));

  assign o_uart_tx = tx_q;
  assign o_busy    = busy_q;
  assign o_level   = fifo_level;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata (i_data),
    .i_pop   (pop),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level),
    .o_rdata (fifo_rdata)
  );

  // Line level implied by the current state; registered into tx_q one edge later.
  always_comb begin
    line_bit = 1'b1;
    case (state_q)
      START:            line_bit = 1'b0;
      DATA:             line_bit = shift_q[0];
      uart_pkg::PARITY: line_bit = par_q;
      default:          line_bit = 1'b1;
    endcase
  end

  // Frame sequencer: state, bit/clock counters, shift register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      tx_q <= line_bit;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= START;
            cnt_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            // The popped word has settled in the FIFO read register by now.
            state_q <= DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= fifo_rdata;
            par_q   <= (^fifo_rdata) ^ (PARITY == PAR_ODD);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (tick) begin
            cnt_q   <= '0;
            shift_q <= shift_q >> 1;
            if (last_data) begin
              bit_q   <= '0;
              state_q <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        uart_pkg::PARITY: begin
          if (tick) begin
            state_q <= STOP;
            cnt_q   <= '0;
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (tick) begin
            cnt_q <= '0;
            if (last_stop) begin
              bit_q <= '0;
              if (!fifo_empty) begin
                state_q <= START;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          bit_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
